// File: rtl/radix8_ntt_sched.sv
// Purpose: address sequencer for an in-place radix-8 NTT over 8-bank memory.
// Latency: rd_addr/tw_addr/stage are valid with rd_en; wr_en/wr_addr trail rd_en/rd_addr by DP_LAT cycles.
// Backpressure: ready=0 stalls issue and holds the group counter; the write pipeline keeps shifting.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a transform (sampled only while idle)
//   ready           memory accepts a read this cycle
//   busy, done      transform in progress / one-cycle completion pulse
//   rd_en, rd_addr  group issue strobe and eight element addresses (element k at [k*LOG_N +: LOG_N])
//   tw_addr, stage  twiddle ROM index and stage index for the issued group
//   wr_en, wr_addr  write-back strobe and addresses, DP_LAT cycles after issue
module radix8_ntt_sched #(
  parameter int LOG_N  = 9,
  parameter int DP_LAT = 4,
  parameter int GW     = LOG_N - 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [8*LOG_N-1:0] rd_addr,
  output logic [LOG_N-1:0]   tw_addr,
  output logic [1:0]         stage,
  output logic               wr_en,
  output logic [8*LOG_N-1:0] wr_addr
);

  localparam int S  = LOG_N / 3;
  localparam int DW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [1:0]      stage_q, stage_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      stage_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          g_d     = '0;
          stage_d = '0;
        end
      end
      ISSUE: begin
        if (ready) begin
          g_d = g_q + GW'(1);
          if (g_q == {GW{1'b1}}) begin
            state_d = DRAIN;
            dcnt_d  = DW'(DP_LAT - 1);
          end
        end
      end
      DRAIN: begin
        // Wait out the datapath so the next stage never reads a word still in flight.
        if (dcnt_q == '0) begin
          if (int'(stage_q) < S - 1) begin
            stage_d = stage_q + 2'd1;
            g_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign rd_en = (state_q == ISSUE) && ready;
  assign stage = stage_q;

  // ---------------- address generation ----------------
  // stride = 8^(S-1-s) is a power of two, so g mod stride is a mask and
  // high*8*stride is simply the unmasked part of g shifted up by 3.
  logic [LOG_N-1:0]   g_ext, low_mask, low, hi8, tw_cur;
  logic [8*LOG_N-1:0] addr_cur;
  int                 sh;

  always_comb begin
    sh       = 3 * (S - 1 - int'(stage_q));
    g_ext    = LOG_N'(g_q);
    low_mask = (LOG_N'(1) << sh) - LOG_N'(1);
    low      = g_ext & low_mask;
    hi8      = (g_ext & ~low_mask) << 3;
    addr_cur = '0;
    for (int k = 0; k < 8; k++) begin
      addr_cur[k*LOG_N +: LOG_N] = hi8 | (LOG_N'(k) << sh) | low;
    end
    tw_cur = low << (3 * int'(stage_q));
  end

  // Outputs show the live group while issuing and the last issued group otherwise.
  logic [8*LOG_N-1:0] addr_hold;
  logic [LOG_N-1:0]   tw_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold <= '0;
      tw_hold   <= '0;
    end else if (rd_en) begin
      addr_hold <= addr_cur;
      tw_hold   <= tw_cur;
    end
  end

  assign rd_addr = rd_en ? addr_cur : addr_hold;
  assign tw_addr = rd_en ? tw_cur   : tw_hold;

  // ---------------- write-back delay line ----------------
  logic [DP_LAT-1:0]                en_sr;
  logic [DP_LAT-1:0][8*LOG_N-1:0]   addr_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_sr   <= '0;
      addr_sr <= '0;
    end else begin
      en_sr[0]   <= rd_en;
      addr_sr[0] <= rd_addr;
      for (int i = 1; i < DP_LAT; i++) begin
        en_sr[i]   <= en_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  assign wr_en   = en_sr[DP_LAT-1];
  assign wr_addr = addr_sr[DP_LAT-1];

endmodule

// File: tb/tb_radix8_ntt_sched.sv
module tb_radix8_ntt_sched;

  localparam int LOG_N  = 9;
  localparam int DP_LAT = 4;
  localparam int S      = 3;
  localparam int NG     = 64;
  localparam int AW     = 8 * LOG_N;
  localparam int MAXC   = 2048;

  logic           clk = 1'b0;
  logic           rst, start, ready;
  logic           busy, done, rd_en, wr_en;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [LOG_N-1:0] tw_addr;
  logic [1:0]     stage;

  radix8_ntt_sched #(.LOG_N(LOG_N), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .tw_addr(tw_addr), .stage(stage), .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rel;
  int done_rel;
  bit rdy_pat [MAXC];
  bit exp_rd  [MAXC];
  int exp_s   [MAXC];
  int exp_g   [MAXC];

  // Reference: element addresses straight from stride/high/low arithmetic.
  function automatic logic [AW-1:0] model_addr(int s, int g);
    int stride = 8 ** (S - 1 - s);
    int hi = g / stride;
    int lo = g % stride;
    logic [AW-1:0] v = '0;
    for (int k = 0; k < 8; k++) v[k*LOG_N +: LOG_N] = LOG_N'(hi * 8 * stride + k * stride + lo);
    return v;
  endfunction

  function automatic logic [LOG_N-1:0] model_tw(int s, int g);
    int stride = 8 ** (S - 1 - s);
    return LOG_N'((g % stride) * (8 ** s));
  endfunction

  function automatic logic [AW-1:0] lanes(int a0, int step);
    logic [AW-1:0] v = '0;
    for (int k = 0; k < 8; k++) v[k*LOG_N +: LOG_N] = LOG_N'(a0 + k * step);
    return v;
  endfunction

  // Cycle-level schedule: each stage issues NG groups on ready cycles, then idles DP_LAT cycles.
  task automatic build_model();
    int t = 1;
    for (int i = 0; i < MAXC; i++) exp_rd[i] = 1'b0;
    for (int s = 0; s < S; s++) begin
      for (int n = 0; n < NG; n++) begin
        while (t < MAXC - 1 && !rdy_pat[t]) t++;
        exp_rd[t] = 1'b1;
        exp_s[t]  = s;
        exp_g[t]  = n;
        t++;
      end
      t += DP_LAT;
    end
    done_rel = t;
  endtask

  task automatic chk(string tag, logic [AW-1:0] got, logic [AW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s rel=%0d got=%0h exp=%0h", tag, rel, got, exp);
    end
  endtask

  task automatic check_cycle(int mode);
    bit exp_wr = (rel >= DP_LAT) ? exp_rd[rel-DP_LAT] : 1'b0;
    chk("busy",  busy,  AW'(rel >= 1 && rel <= done_rel));
    chk("done",  done,  AW'(rel == done_rel));
    chk("rd_en", rd_en, AW'(exp_rd[rel]));
    chk("wr_en", wr_en, AW'(exp_wr));
    if (exp_rd[rel]) begin
      chk("rd_addr", rd_addr, model_addr(exp_s[rel], exp_g[rel]));
      chk("tw_addr", tw_addr, AW'(model_tw(exp_s[rel], exp_g[rel])));
      chk("stage",   stage,   AW'(exp_s[rel]));
    end
    if (exp_wr) chk("wr_addr", wr_addr, model_addr(exp_s[rel-DP_LAT], exp_g[rel-DP_LAT]));
    if (mode == 0) begin
      case (rel)
        1:   begin chk("s0g0_addr", rd_addr, lanes(0, 64));  chk("s0g0_tw", tw_addr, AW'(0)); end
        2:   begin chk("s0g1_addr", rd_addr, lanes(1, 64));  chk("s0g1_tw", tw_addr, AW'(1)); end
        78:  begin chk("s1g9_addr", rd_addr, lanes(65, 8));  chk("s1g9_tw", tw_addr, AW'(8)); end
        142: begin chk("s2g5_addr", rd_addr, lanes(40, 1));  chk("s2g5_tw", tw_addr, AW'(0));
                   chk("s2g5_stage", stage, AW'(2)); end
        205: chk("nostall_done", done, AW'(1));
        default: ;
      endcase
    end
    if (mode == 1 && rel == 215) chk("stall_done", done, AW'(1));
  endtask

  task automatic run(int mode, int stop_rel);
    for (int r = 0; r <= stop_rel; r++) begin
      @(posedge clk); #1;
      rel = r;
      if (r == 0) start = 1'b1;
      else if (mode == 2 && r <= done_rel) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      ready = rdy_pat[r];
      @(negedge clk);
      check_cycle(mode);
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"},  busy,    '0);
    chk({tag, "_done"},  done,    '0);
    chk({tag, "_rd_en"}, rd_en,   '0);
    chk({tag, "_wr_en"}, wr_en,   '0);
    chk({tag, "_rd"},    rd_addr, '0);
    chk({tag, "_wr"},    wr_addr, '0);
    chk({tag, "_tw"},    tw_addr, '0);
    chk({tag, "_stage"}, stage,   '0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; rel = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Free-running transform.
    for (int i = 0; i < MAXC; i++) rdy_pat[i] = 1'b1;
    build_model();
    run(0, done_rel + 4);

    // Ten-cycle stall in the middle of stage 1.
    for (int i = 0; i < MAXC; i++) rdy_pat[i] = !(i >= 100 && i < 110);
    build_model();
    run(1, done_rel + 4);

    // Random ready with stray start pulses while busy.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < MAXC; i++) rdy_pat[i] = ($urandom_range(0, 3) != 0);
      build_model();
      run(2, done_rel + 4);
    end

    // Reset (with start held high) during the stage-1 drain window.
    for (int i = 0; i < MAXC; i++) rdy_pat[i] = 1'b1;
    build_model();
    run(3, 133);
    @(posedge clk); #1;
    rel = 134; rst = 1'b1; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    rel = 135;
    check_all_zero("abort");
    for (int r = 136; r < 146; r++) begin
      @(posedge clk); #1;
      rel = r;
      @(negedge clk);
      chk("post_rst_wr_en", wr_en, '0);
      chk("post_rst_busy",  busy,  '0);
      chk("post_rst_rd_en", rd_en, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
